exec_unit: RTL
==============

# exec_unit

Sequencing execute/writeback stage of the 8-bit CPU. It sits between the instruction decoder and the register file. It accepts one decoded operation per handshake and drives the register-file read addresses. It captures both operands after the register file's one-cycle registered read, computes the result (single-cycle ALU ops or an 8-cycle sequential multiply), then writes back through register-file port A, which is shared between reads and writes.

## Interface
Parameters:
- DW, 8, datapath width
- AW, 6, register address width (64 registers)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoder presents an operation
- in_ready  out  1  unit idle and able to accept
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MOV, 8 MUL, 9 CMP, 10–15 illegal
- src_a, src_b, dst  in  AW  operand/destination register addresses
- use_imm  in  1  operand B taken from imm instead of the register file
- imm  in  DW  immediate operand
- aa, ab  out  AW  register-file read addresses
- ad  out  AW  register-file write address
- wr  out  1  register-file write enable
- rd  out  DW  register-file write data
- ra, rb  in  DW  register-file read data, valid one cycle after the address is sampled
- flags  out  3  {N, C, Z}
- mul_hi  out  DW  high byte of the last MUL product
- done  out  1  one-cycle pulse when an operation retires
- err  out  1  one-cycle pulse on an illegal opcode

## Operation
- States: IDLE, ISSUE, OPER, MUL, WB.
- IDLE: in_ready=1. When in_valid&in_ready, latch op/src_a/src_b/dst/use_imm/imm and drive aa=src_a, ab=src_b (registered), then go to ISSUE.
- ISSUE: the register file samples aa/ab. Go to OPER.
- OPER: ra/rb are valid. Latch opa=ra and opb=use_imm?imm:rb, then dispatch:
  - ADD/SUB/AND/OR/XOR/SHL/SHR/MOV: compute the result into rd, go to WB.
  - MUL: start mul8_seq, go to MUL.
  - CMP: compute opa−opb, update flags only, pulse done, go to IDLE.
  - Illegal opcode: pulse err, leave flags unchanged, no write, go to IDLE.
- MUL: wait for mul8_seq done (8 cycles). rd=prod[7:0], mul_hi=prod[15:8]. Go to WB.
- WB: wr=1, ad=dst, rd held, done=1. Flags update in this cycle. Go to IDLE.
- Arithmetic is 8-bit, modulo 256. The wider internal result is used only for C.
  - ADD: C = carry-out.
  - SUB/CMP: C = borrow (opa<opb, unsigned).
  - SHL/SHR: shift by one. C = the bit shifted out; zero fill.
  - AND/OR/XOR/MOV: C=0. MOV result = opb.
  - MUL: C = (prod[15:8]≠0).
  - Z = (result==0). N = result[7].
- Port-A conflict: during WB the register file routes port A to ad, so ra is garbage. The unit never samples ra outside OPER.
- dst equal to a source register is legal. Operands are already latched before WB.
- in_valid while busy: ignored. The decoder must hold the operation until in_ready.

## Timing
- Reset values: in_ready=0 during rst, 1 in the first cycle after. State=IDLE, aa=ab=ad=0, wr=0, rd=0, flags=0, mul_hi=0, done=0, err=0.
- Accept at edge T0. ISSUE T1, OPER T2, WB T3 (wr=1 for exactly one cycle). in_ready=1 again at T4. Single-cycle ops take 4 cycles per operation.
- CMP and illegal opcodes: retire in OPER at T2. in_ready=1 at T3.
- MUL: OPER T2, MUL T3..T10, WB T11, in_ready T12.
- rst asserted mid-operation (any state): next edge forces IDLE. No write is issued, the mul8_seq iteration is aborted, and flags clear.
- done and err are never asserted together. wr is never asserted outside WB.

## Structure
- exec_pkg holds the opcode localparams (OP_ADD..OP_CMP), the state encoding (IDLE..WB), and the flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2).
- Sub-module mul8_seq is an 8×8 shift-add multiplier.
  - Ports: clk, rst, start, a, b, prod[15:0], done.
  - One partial product per cycle; done is pulsed on the 8th iteration.
  - Restarting while busy is not allowed; rst aborts.
- exec_unit holds the FSM, operand latches, single-cycle ALU and flag logic.

## Test plan
- Register r3=0x7F, r4=0x01; ADD src_a=3, src_b=4, dst=5 -> wr pulse at T3 with ad=5, rd=0x80; flags N=1, C=0, Z=0; done at T3.
- SUB r1=0x10, imm=0x20, use_imm=1, dst=2 -> rd=0xF0, C=1, N=1; r2 reads back 0xF0.
- MUL r6=0xFF, r7=0xFF, dst=8 -> wr at T11 with rd=0x01; mul_hi=0xFE; C=1.
- CMP r0=0x33 vs imm=0x33 -> no wr; Z=1, C=0; done at T2; in_ready at T3. Then op=12 -> err pulse, flags unchanged, no wr.
- Back-to-back ADD r1,r1→r1 twice with in_valid held high (r1=0x01) -> second op accepted at T4; final r1=0x04. ra is never sampled during WB.
- rst asserted during MUL cycle T6 -> wr never asserts; all outputs return to reset values; in_ready=1 in the first cycle after rst drops.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the execute/writeback stage.
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [2:0] {IDLE, ISSUE, OPER, MUL, WB} state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/mul8_seq.sv
// 8x8 shift-add multiplier: one partial product per cycle, done pulses on the 8th iteration.
module mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod,
    output logic        done
);

    logic [15:0] acc_q, mcand_q, addend, sum;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;
    logic        busy_q;

    // prod includes the current partial product so it is complete while done is high
    always_comb begin
        addend = mplier_q[0] ? mcand_q : 16'd0;
        sum    = acc_q + addend;
        prod   = sum;
        done   = busy_q && (cnt_q == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {8'd0, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= sum;
            mcand_q  <= {mcand_q[14:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[7:1]};
            cnt_q    <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute/writeback stage: issues register reads, runs the ALU or sequential multiply,
// and writes the result back through the shared register-file port A.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] dst,
    input  logic          use_imm,
    input  logic [DW-1:0] imm,
    output logic [AW-1:0] aa,
    output logic [AW-1:0] ab,
    output logic [AW-1:0] ad,
    output logic          wr,
    output logic [DW-1:0] rd,
    input  logic [DW-1:0] ra,
    input  logic [DW-1:0] rb,
    output logic [2:0]    flags,
    output logic [DW-1:0] mul_hi,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [3:0]    op_q;
    logic [AW-1:0] dst_q, aa_q, ab_q;
    logic          use_imm_q;
    logic [DW-1:0] imm_q, rd_q, mul_hi_q;
    logic [2:0]    flags_q;

    logic [DW-1:0] opa, opb, alu_res;
    logic [DW:0]   alu_wide;
    logic [2:0]    alu_flags, mul_flags;
    logic          mul_start, mul_done;
    logic [15:0]   mul_prod;

    // Operands are only meaningful in OPER; ra is never looked at in any other state
    always_comb begin
        opa      = ra;
        opb      = use_imm_q ? imm_q : rb;
        alu_wide = '0;
        case (op_q)
            OP_ADD:         alu_wide = {1'b0, opa} + {1'b0, opb};
            OP_SUB, OP_CMP: alu_wide = {1'b0, opa} - {1'b0, opb};
            OP_AND:         alu_wide = {1'b0, opa & opb};
            OP_OR:          alu_wide = {1'b0, opa | opb};
            OP_XOR:         alu_wide = {1'b0, opa ^ opb};
            OP_SHL:         alu_wide = {opa, 1'b0};
            OP_SHR:         alu_wide = {opa[0], 1'b0, opa[DW-1:1]};
            OP_MOV:         alu_wide = {1'b0, opb};
            default:        alu_wide = '0;
        endcase
        alu_res           = alu_wide[DW-1:0];
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[DW-1];
        alu_flags[FLAG_C] = alu_wide[DW];
        alu_flags[FLAG_Z] = (alu_res == '0);
        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_prod[7];
        mul_flags[FLAG_C] = |mul_prod[15:8];
        mul_flags[FLAG_Z] = (mul_prod[7:0] == 8'd0);
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE:  if (in_valid) state_d = ISSUE;
            ISSUE: state_d = OPER;
            OPER: begin
                if (!op_legal(op_q) || op_q == OP_CMP) begin
                    state_d = IDLE;
                end else if (op_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end else begin
                    state_d = WB;
                end
            end
            MUL:     if (mul_done) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Combinational outputs are masked during rst so nothing leaks before the reset edge
        in_ready = (state_q == IDLE) && !rst;
        wr       = (state_q == WB) && !rst;
        ad       = wr ? dst_q : '0;
        done     = !rst && ((state_q == WB) || (state_q == OPER && op_q == OP_CMP));
        err      = !rst && (state_q == OPER) && !op_legal(op_q);
        aa       = aa_q;
        ab       = ab_q;
        rd       = rd_q;
        flags    = flags_q;
        mul_hi   = mul_hi_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            aa_q      <= '0;
            ab_q      <= '0;
            rd_q      <= '0;
            mul_hi_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                op_q      <= op;
                dst_q     <= dst;
                use_imm_q <= use_imm;
                imm_q     <= imm;
                aa_q      <= src_a;
                ab_q      <= src_b;
            end
            if (state_q == OPER && op_legal(op_q) && op_q != OP_MUL) begin
                flags_q <= alu_flags;
                if (op_q != OP_CMP) begin
                    rd_q <= alu_res;
                end
            end
            if (state_q == MUL && mul_done) begin
                rd_q     <= mul_prod[DW-1:0];
                mul_hi_q <= mul_prod[15:8];
                flags_q  <= mul_flags;
            end
        end
    end

    mul8_seq u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (opa),
        .b     (opb),
        .prod  (mul_prod),
        .done  (mul_done)
    );

endmodule
